// File: rtl/vga_timing_defs_pkg.sv
// Shared VGA timing constants (default 640x480@60) and small helpers,
// used by the sync generator and the colour stage.
package vga_timing_defs_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // The sync delay line has at most three stages.
  function automatic int clamp_sync_dly(input int dly);
    if (dly < 0) return 0;
    if (dly > 3) return 3;
    return dly;
  endfunction

  function automatic logic sync_level(input logic in_sync, input logic pol);
    return in_sync ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: free-running position counter with active/sync decode
// and a terminal-count flag used to chain the vertical axis.
module vga_axis_counter
  import vga_timing_defs_pkg::*;
#(
  parameter int   ACTIVE = DEF_H_ACTIVE,
  parameter int   FP     = DEF_H_FP,
  parameter int   SYNC   = DEF_H_SYNC,
  parameter int   BP     = DEF_H_BP,
  parameter logic POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             active,
  output logic             sync,
  output logic             wrap
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  // One extra bit so a region ending exactly at 1024 still compares correctly.
  localparam logic [CNT_W:0] ACT_END    = (CNT_W + 1)'(ACTIVE);
  localparam logic [CNT_W:0] SYNC_START = (CNT_W + 1)'(ACTIVE + FP);
  localparam logic [CNT_W:0] SYNC_END   = (CNT_W + 1)'(ACTIVE + FP + SYNC);

  logic [CNT_W:0] cnt_x;

  assign cnt_x  = {1'b0, cnt};
  assign wrap   = (cnt == LAST);
  assign active = (cnt_x < ACT_END);
  assign sync   = sync_level((cnt_x >= SYNC_START) && (cnt_x < SYNC_END), POL);

  // NOTE: reset is sampled on the clock edge only, so it lives inside the
  // clocked branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc) begin
      // NOTE: state uses non-blocking assignment so every register samples
      // pre-edge values regardless of statement order.
      cnt <= wrap ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel coordinates, active-video flag, frame pulse,
// and HSYNC/VSYNC delayed to line up with the registered colour stage.
module vga_sync_gen
  import vga_timing_defs_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int SYNC_DLY = 1
) (
  input  logic             VGA_CLK,
  input  logic             RST_N,
  input  logic             PIX_EN,
  output logic [CNT_W-1:0] X,
  output logic [CNT_W-1:0] Y,
  output logic             valid,
  output logic             VGA_HSYNC,
  output logic             VGA_VSYNC,
  output logic             frame_start
);

  localparam int   DLY = clamp_sync_dly(SYNC_DLY);
  localparam logic POL = (SYNC_POL != 0);

  // RST_N is active-high despite its name.
  logic rst;
  assign rst = RST_N;

  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic             h_active, v_active;
  logic             h_sync, v_sync;
  logic             h_wrap, v_wrap;
  logic             v_inc;
  logic             frame_tick_q;
  logic             hs_tap, vs_tap;

  assign v_inc = PIX_EN & h_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(POL)
  ) u_h (
    .clk(VGA_CLK), .rst(rst), .inc(PIX_EN),
    .cnt(h_cnt), .active(h_active), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(POL)
  ) u_v (
    .clk(VGA_CLK), .rst(rst), .inc(v_inc),
    .cnt(v_cnt), .active(v_active), .sync(v_sync), .wrap(v_wrap)
  );

  // The delay line counts pixel ticks, not clocks, so it tracks PIX_EN.
  generate
    if (DLY == 0) begin : g_no_dly
      assign hs_tap = h_sync;
      assign vs_tap = v_sync;
    end else begin : g_dly
      logic [DLY-1:0] hs_pipe, vs_pipe;

      always_ff @(posedge VGA_CLK) begin
        if (rst) begin
          hs_pipe <= {DLY{~POL}};
          vs_pipe <= {DLY{~POL}};
        end else if (PIX_EN) begin
          hs_pipe <= DLY'({hs_pipe, h_sync});
          vs_pipe <= DLY'({vs_pipe, v_sync});
        end
      end

      assign hs_tap = hs_pipe[DLY-1];
      assign vs_tap = vs_pipe[DLY-1];
    end
  endgenerate

  // frame_tick_q marks the wrap tick; the pulse follows one clock later so it
  // coincides with X/Y showing (0,0). The post-reset frame never wraps into it.
  always_ff @(posedge VGA_CLK) begin
    if (rst) begin
      X            <= '0;
      Y            <= '0;
      valid        <= 1'b0;
      VGA_HSYNC    <= ~POL;
      VGA_VSYNC    <= ~POL;
      frame_tick_q <= 1'b0;
      frame_start  <= 1'b0;
    end else begin
      X            <= h_cnt;
      Y            <= v_cnt;
      valid        <= h_active & v_active;
      VGA_HSYNC    <= hs_tap;
      VGA_VSYNC    <= vs_tap;
      frame_tick_q <= PIX_EN & h_wrap & v_wrap;
      frame_start  <= frame_tick_q;
    end
  end

endmodule
